// File: rtl/fir_channel_scheduler.sv
// Round-robin scheduler sharing one FIR core between NUM_CH channels, with a watchdog on the core's done pulse.
// Latency: grant->start 1 cycle; done->o_dout_valid 1 cycle; handshake->next start 2 cycles.
// Backpressure: the result is held in OUT until i_ready; no new grant is made while a result is pending.
module fir_channel_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4,
  parameter int TIMEOUT    = 64,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_en,
  input  logic [NUM_CH-1:0]            i_req,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_sample,
  output logic [NUM_CH-1:0]            o_ack,
  output logic                         o_fir_start,
  output logic [DATA_WIDTH-1:0]        o_fir_din,
  output logic [CH_W-1:0]              o_fir_ch,
  input  logic                         i_fir_done,
  input  logic [DATA_WIDTH-1:0]        i_fir_dout,
  output logic [DATA_WIDTH-1:0]        o_dout,
  output logic [CH_W-1:0]              o_dout_ch,
  output logic                         o_dout_valid,
  input  logic                         i_ready,
  output logic                         o_busy,
  output logic                         o_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t           state;
  logic [CH_W-1:0]  last;
  logic [CNT_W-1:0] cnt;

  logic             grant_found;
  logic [CH_W-1:0]  grant_idx;
  logic [NUM_CH-1:0] grant_onehot;

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    int              idx;
    logic [CH_W-1:0] idx_c;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    idx_c       = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx   = (int'(last) + i) % NUM_CH;
      idx_c = CH_W'(idx);
      if (!grant_found && i_req[idx_c]) begin
        grant_found = 1'b1;
        grant_idx   = idx_c;
      end
    end
    grant_onehot = {{(NUM_CH-1){1'b0}}, 1'b1} << grant_idx;
  end

  // Job sequencing FSM; every output is a register updated here.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      last         <= CH_W'(NUM_CH - 1);
      cnt          <= '0;
      o_ack        <= '0;
      o_fir_start  <= 1'b0;
      o_fir_din    <= '0;
      o_fir_ch     <= '0;
      o_dout       <= '0;
      o_dout_ch    <= '0;
      o_dout_valid <= 1'b0;
      o_busy       <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      // Pulses default low and are raised for one cycle only where needed.
      o_ack       <= '0;
      o_fir_start <= 1'b0;
      o_err       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_en && grant_found) begin
            o_fir_din   <= i_sample[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            o_fir_ch    <= grant_idx;
            last        <= grant_idx;
            o_ack       <= grant_onehot;
            o_fir_start <= 1'b1;
            o_busy      <= 1'b1;
            state       <= S_START;
          end
        end
        S_START: begin
          // Core done is ignored here; the watchdog starts counting next cycle.
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_fir_done) begin
            // A done arriving on the final watchdog cycle still wins.
            o_dout       <= i_fir_dout;
            o_dout_ch    <= o_fir_ch;
            o_dout_valid <= 1'b1;
            state        <= S_OUT;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            // Abort without output; last stays on the failing channel.
            o_err  <= 1'b1;
            o_busy <= 1'b0;
            state  <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_OUT: begin
          if (i_ready) begin
            o_dout_valid <= 1'b0;
            o_busy       <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  // Invariants on the registered outputs.
  a_ack_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n) $onehot0(o_ack));
  a_ack_with_start: assert property (@(posedge i_clk) disable iff (!i_rst_n) (o_fir_start == (|o_ack)));
  a_out_hold: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (o_dout_valid && !i_ready) |=> (o_dout_valid && $stable(o_dout) && $stable(o_dout_ch)));

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Directed bench for fir_channel_scheduler: reset, single job, fairness, backpressure, watchdog, enable gating, reset mid-job.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// The serializer ready and core done are driven explicitly by each scenario.
module tb_fir_channel_scheduler;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_en;
  logic [3:0]  i_req;
  logic [63:0] i_sample;
  logic [3:0]  o_ack;
  logic        o_fir_start;
  logic [15:0] o_fir_din;
  logic [1:0]  o_fir_ch;
  logic        i_fir_done;
  logic [15:0] i_fir_dout;
  logic [15:0] o_dout;
  logic [1:0]  o_dout_ch;
  logic        o_dout_valid;
  logic        i_ready;
  logic        o_busy;
  logic        o_err;

  int checks = 0;
  int errors = 0;

  fir_channel_scheduler #(.DATA_WIDTH(16), .NUM_CH(4), .TIMEOUT(64)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_req(i_req), .i_sample(i_sample),
    .o_ack(o_ack), .o_fir_start(o_fir_start), .o_fir_din(o_fir_din), .o_fir_ch(o_fir_ch),
    .i_fir_done(i_fir_done), .i_fir_dout(i_fir_dout), .o_dout(o_dout), .o_dout_ch(o_dout_ch),
    .o_dout_valid(o_dout_valid), .i_ready(i_ready), .o_busy(o_busy), .o_err(o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic pulse_reset();
    i_rst_n = 1'b0;
    #2;
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_en = 1'b0; i_req = '0; i_sample = '0;
    i_fir_done = 1'b0; i_fir_dout = '0; i_ready = 1'b0;
    #12;
    checks++;
    if ({o_ack, o_fir_start, o_fir_din, o_fir_ch, o_dout, o_dout_ch, o_dout_valid, o_busy, o_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ack=%b st=%b din=%h ch=%0d dout=%h dch=%0d v=%b busy=%b err=%b want all 0",
               o_ack, o_fir_start, o_fir_din, o_fir_ch, o_dout, o_dout_ch, o_dout_valid, o_busy, o_err);
    end
    tick();
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_job();
    i_en = 1'b1;
    i_sample[2*16 +: 16] = 16'h1234;
    i_req = 4'b0100;
    tick();
    checks++;
    if (o_ack !== 4'b0100 || o_fir_start !== 1'b1) begin
      errors++; $display("FAIL single_grant got ack=%b start=%b want ack=0100 start=1", o_ack, o_fir_start);
    end
    checks++;
    if (o_fir_din !== 16'h1234 || o_fir_ch !== 2'd2) begin
      errors++; $display("FAIL single_latch got din=%h ch=%0d want din=1234 ch=2", o_fir_din, o_fir_ch);
    end
    checks++;
    if (o_busy !== 1'b1) begin
      errors++; $display("FAIL single_busy got %b want 1", o_busy);
    end
    i_req = 4'b0000;
    tick();
    checks++;
    if (o_ack !== 4'b0000 || o_fir_start !== 1'b0) begin
      errors++; $display("FAIL single_pulse_width got ack=%b start=%b want 0000/0", o_ack, o_fir_start);
    end
    for (int k = 0; k < 4; k++) tick();
    i_fir_done = 1'b1; i_fir_dout = 16'hABCD;
    checks++;
    if (o_dout_valid !== 1'b0) begin
      errors++; $display("FAIL single_valid_early got %b want 0", o_dout_valid);
    end
    tick();
    i_fir_done = 1'b0; i_fir_dout = '0;
    checks++;
    if (o_dout_valid !== 1'b1 || o_dout !== 16'hABCD || o_dout_ch !== 2'd2) begin
      errors++; $display("FAIL single_result got v=%b dout=%h ch=%0d want v=1 dout=abcd ch=2", o_dout_valid, o_dout, o_dout_ch);
    end
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    checks++;
    if (o_dout_valid !== 1'b0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL single_handshake got v=%b busy=%b want 0/0", o_dout_valid, o_busy);
    end
  endtask

  task automatic test_fairness();
    int exp_ch;
    logic [3:0] exp_ack;
    pulse_reset();
    i_en = 1'b1; i_ready = 1'b1; i_req = 4'b1111;
    for (int j = 0; j < 6; j++) begin
      exp_ch = j % 4;
      exp_ack = 4'b0001 << exp_ch;
      for (int k = 0; k < 20; k++) begin
        if (o_fir_start === 1'b1) break;
        tick();
      end
      checks++;
      if (o_fir_start !== 1'b1 || o_fir_ch !== 2'(exp_ch) || o_ack !== exp_ack) begin
        errors++; $display("FAIL fair_grant_%0d got start=%b ch=%0d ack=%b want start=1 ch=%0d ack=%b",
                           j, o_fir_start, o_fir_ch, o_ack, exp_ch, exp_ack);
      end
      i_req[exp_ch] = 1'b0;
      tick();
      i_req[exp_ch] = 1'b1;
      i_fir_done = 1'b1; i_fir_dout = 16'h1000 + 16'(j);
      tick();
      i_fir_done = 1'b0;
      checks++;
      if (o_dout_valid !== 1'b1 || o_dout_ch !== 2'(exp_ch) || o_dout !== 16'h1000 + 16'(j)) begin
        errors++; $display("FAIL fair_result_%0d got v=%b ch=%0d dout=%h want v=1 ch=%0d dout=%h",
                           j, o_dout_valid, o_dout_ch, o_dout, exp_ch, 16'h1000 + 16'(j));
      end
      tick();
    end
    i_req = 4'b0000; i_ready = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    i_sample[0 +: 16] = 16'h0BB0;
    i_req = 4'b0001;
    tick();
    checks++;
    if (o_fir_start !== 1'b1 || o_fir_ch !== 2'd0) begin
      errors++; $display("FAIL bp_grant got start=%b ch=%0d want 1/0", o_fir_start, o_fir_ch);
    end
    i_req = 4'b0000;
    tick();
    i_fir_done = 1'b1; i_fir_dout = 16'h5A5A;
    tick();
    i_fir_done = 1'b0;
    i_req = 4'b0010;
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (o_dout_valid !== 1'b1 || o_dout !== 16'h5A5A || o_dout_ch !== 2'd0 || o_ack !== 4'b0000) begin
        errors++; $display("FAIL bp_hold_%0d got v=%b dout=%h ch=%0d ack=%b want 1/5a5a/0/0000",
                           k, o_dout_valid, o_dout, o_dout_ch, o_ack);
      end
      tick();
    end
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    checks++;
    if (o_dout_valid !== 1'b0 || o_fir_start !== 1'b0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL bp_release got v=%b start=%b busy=%b want 0/0/0", o_dout_valid, o_fir_start, o_busy);
    end
    tick();
    checks++;
    if (o_fir_start !== 1'b1 || o_ack !== 4'b0010) begin
      errors++; $display("FAIL bp_next_start got start=%b ack=%b want 1/0010", o_fir_start, o_ack);
    end
    i_req = 4'b0000;
    tick();
    i_fir_done = 1'b1; i_fir_dout = 16'h0001;
    tick();
    i_fir_done = 1'b0; i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
  endtask

  task automatic test_watchdog();
    bit saw_valid;
    bit saw_err;
    saw_valid = 1'b0; saw_err = 1'b0;
    i_req = 4'b0100;
    tick();
    checks++;
    if (o_fir_start !== 1'b1 || o_fir_ch !== 2'd2) begin
      errors++; $display("FAIL wd_grant got start=%b ch=%0d want 1/2", o_fir_start, o_fir_ch);
    end
    i_req = 4'b1000;
    for (int k = 0; k < 64; k++) begin
      tick();
      if (o_dout_valid) saw_valid = 1'b1;
      if (o_err) saw_err = 1'b1;
    end
    checks++;
    if (saw_err !== 1'b0 || o_busy !== 1'b1) begin
      errors++; $display("FAIL wd_early got err_seen=%b busy=%b want 0/1", saw_err, o_busy);
    end
    tick();
    checks++;
    if (o_err !== 1'b1 || o_busy !== 1'b0 || o_dout_valid !== 1'b0) begin
      errors++; $display("FAIL wd_abort got err=%b busy=%b v=%b want 1/0/0", o_err, o_busy, o_dout_valid);
    end
    checks++;
    if (saw_valid !== 1'b0) begin
      errors++; $display("FAIL wd_no_output got valid_seen=%b want 0", saw_valid);
    end
    tick();
    checks++;
    if (o_err !== 1'b0 || o_fir_start !== 1'b1 || o_ack !== 4'b1000) begin
      errors++; $display("FAIL wd_next got err=%b start=%b ack=%b want 0/1/1000", o_err, o_fir_start, o_ack);
    end
    i_req = 4'b0000;
    tick();
    i_fir_done = 1'b1; i_fir_dout = 16'h3333;
    tick();
    i_fir_done = 1'b0;
    checks++;
    if (o_dout_valid !== 1'b1 || o_dout_ch !== 2'd3 || o_dout !== 16'h3333) begin
      errors++; $display("FAIL wd_served got v=%b ch=%0d dout=%h want 1/3/3333", o_dout_valid, o_dout_ch, o_dout);
    end
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
  endtask

  task automatic test_enable_gating();
    bit bad;
    bad = 1'b0;
    i_en = 1'b0; i_req = 4'b1000;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (o_ack !== 4'b0000 || o_busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++; $display("FAIL en_block got activity=%b want 0 (ack=%b busy=%b)", bad, o_ack, o_busy);
    end
    i_en = 1'b1;
    tick();
    checks++;
    if (o_ack !== 4'b1000 || o_fir_start !== 1'b1) begin
      errors++; $display("FAIL en_grant got ack=%b start=%b want 1000/1", o_ack, o_fir_start);
    end
    i_req = 4'b0000;
    tick();
    i_fir_done = 1'b1; i_fir_dout = 16'h4444;
    tick();
    i_fir_done = 1'b0; i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
  endtask

  task automatic test_reset_mid_job();
    i_sample[0 +: 16] = 16'h7777;
    i_req = 4'b0001;
    tick();
    checks++;
    if (o_fir_ch !== 2'd0 || o_fir_din !== 16'h7777) begin
      errors++; $display("FAIL rst_pre_grant got ch=%0d din=%h want 0/7777", o_fir_ch, o_fir_din);
    end
    i_req = 4'b0000;
    tick();
    tick();
    i_rst_n = 1'b0;
    #2;
    checks++;
    if ({o_ack, o_fir_start, o_fir_din, o_fir_ch, o_dout, o_dout_ch, o_dout_valid, o_busy, o_err} !== '0) begin
      errors++; $display("FAIL rst_async got din=%h busy=%b v=%b want all 0", o_fir_din, o_busy, o_dout_valid);
    end
    i_fir_done = 1'b1; i_fir_dout = 16'hDEAD;
    tick();
    tick();
    i_rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (o_dout_valid !== 1'b0 || o_dout !== 16'h0000 || o_busy !== 1'b0) begin
      errors++; $display("FAIL rst_late_done got v=%b dout=%h busy=%b want 0/0000/0", o_dout_valid, o_dout, o_busy);
    end
    i_fir_done = 1'b0;
    i_req = 4'b1111;
    tick();
    checks++;
    if (o_fir_start !== 1'b1 || o_fir_ch !== 2'd0 || o_ack !== 4'b0001) begin
      errors++; $display("FAIL rst_first_grant got start=%b ch=%0d ack=%b want 1/0/0001", o_fir_start, o_fir_ch, o_ack);
    end
    i_req = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_fairness();
    test_backpressure();
    test_watchdog();
    test_enable_gating();
    test_reset_mid_job();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
